uart_tx_gen2: RTL and testbench

UART_TX_GEN2 -- requirements
Module: uart_tx_gen2

---
 rtl/uart_tx_gen2.sv | 153 +++++++++++++++
 tb/tb_uart_tx_gen2.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_gen2.sv
// uart_tx_gen2: framed UART transmitter with per-word config latched at acceptance.
// Define UART_TX_GEN2_FIFO_EN for a FIFO_DEPTH-entry input buffer; otherwise a single holding register.
module uart_tx_gen2 #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    output logic                  Data_Ready,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic                  busy,
    output logic                  TX_OUT
);
    localparam int EW = DATA_WIDTH + 3 + PRESCALE_W;

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_gen2: illegal DATA_WIDTH or FIFO_DEPTH");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  r_state;
    logic [PRESCALE_W-1:0]   r_cnt, r_pre;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [3:0]              r_bit;
    logic                    r_par_en, r_par, r_stop2, r_stop_n;
    logic [EW-1:0]           w_in, w_head;
    logic [PRESCALE_W-1:0]   w_pre_in;
    logic                    w_pend, w_push, w_pop, w_last, w_stop_done;

    // Buffer entry: {prescale, stop2, par_typ, par_en, data}
    assign w_in        = {PRESCALE, STOP2, PAR_TYP, PAR_EN, P_DATA};
    assign w_pre_in    = w_head[EW-1 -: PRESCALE_W];
    assign w_push      = Data_Valid && Data_Ready;
    assign w_last      = r_cnt == r_pre - 1'b1;
    assign w_stop_done = r_state == STOP && w_last && !(r_stop2 && !r_stop_n);
    assign w_pop       = w_pend && (r_state == IDLE || w_stop_done);

`ifdef UART_TX_GEN2_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_fill;

    assign Data_Ready = r_fill != (AW+1)'(FIFO_DEPTH);
    assign w_pend     = r_fill != '0;
    assign w_head     = r_mem[r_rp];

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wp] <= w_in;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fill <= '0;
        end else begin
            r_wp   <= r_wp + AW'(w_push);
            r_rp   <= r_rp + AW'(w_pop);
            r_fill <= r_fill + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
`else
    logic [EW-1:0] r_hold;
    logic          r_pend;

    assign Data_Ready = r_state == IDLE && !r_pend;
    assign w_pend     = r_pend;
    assign w_head     = r_hold;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hold <= '0;
            r_pend <= 1'b0;
        end else if (w_push) begin
            r_hold <= w_in;
            r_pend <= 1'b1;
        end else if (w_pop) begin
            r_pend <= 1'b0;
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            TX_OUT   <= 1'b1;
            busy     <= 1'b0;
            r_cnt    <= '0;
            r_pre    <= '0;
            r_shift  <= '0;
            r_bit    <= '0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_stop2  <= 1'b0;
            r_stop_n <= 1'b0;
        end else begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_pop) begin
                r_shift  <= w_head[DATA_WIDTH-1:0];
                r_par_en <= w_head[DATA_WIDTH];
                r_par    <= ^w_head[DATA_WIDTH-1:0] ^ w_head[DATA_WIDTH+1];
                r_stop2  <= w_head[DATA_WIDTH+2];
                r_pre    <= (w_pre_in == '0) ? PRESCALE_W'(1) : w_pre_in;
                r_cnt    <= '0;
                r_state  <= START;
                TX_OUT   <= 1'b0;
                busy     <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: r_cnt <= '0;
                    START: if (w_last) begin
                        r_state <= DATA;
                        r_bit   <= '0;
                        TX_OUT  <= r_shift[0];
                    end
                    DATA: if (w_last) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit == 4'(DATA_WIDTH - 1)) begin
                            r_state  <= r_par_en ? PARITY : STOP;
                            TX_OUT   <= r_par_en ? r_par : 1'b1;
                            r_stop_n <= 1'b0;
                        end else begin
                            r_bit  <= r_bit + 1'b1;
                            TX_OUT <= r_shift[1];
                        end
                    end
                    PARITY: if (w_last) begin
                        r_state  <= STOP;
                        TX_OUT   <= 1'b1;
                        r_stop_n <= 1'b0;
                    end
                    STOP: if (w_last) begin
                        if (r_stop2 && !r_stop_n) r_stop_n <= 1'b1;
                        else begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_gen2.sv
// tb_uart_tx_gen2: scoreboard bench; expected frames are built from the framing rules and checked by a line monitor.
module tb_uart_tx_gen2;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       dv, rdy, par_en, par_typ, stop2, busy, tx;
    logic [7:0] prescale;

    typedef struct {
        logic [15:0] bits;
        int          nb;
        int          pre;
    } frame_t;

    frame_t sb[$];
    frame_t cur;
    int     checks = 0;
    int     errors = 0;
    int     n_frames = 0;
    int     idx, mis;
    bit     active = 0;

    uart_tx_gen2 dut (
        .CLK(clk), .RST(rst), .P_DATA(p_data), .Data_Valid(dv), .Data_Ready(rdy),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .PRESCALE(prescale),
        .busy(busy), .TX_OUT(tx)
    );

    always #5 clk = ~clk;

    function automatic frame_t mk(logic [7:0] d, logic pe, logic pt, logic s2, logic [7:0] p);
        frame_t f;
        f.bits = '0;
        f.nb   = 1;
        for (int i = 0; i < 8; i++) begin
            f.bits[f.nb] = d[i];
            f.nb++;
        end
        if (pe) begin
            f.bits[f.nb] = (($countones(d) % 2) == 1) ^ pt;
            f.nb++;
        end
        for (int i = 0; i < 1 + int'(s2); i++) begin
            f.bits[f.nb] = 1'b1;
            f.nb++;
        end
        f.pre = (p == 0) ? 1 : int'(p);
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Line monitor: each falling TX_OUT outside a frame starts the next expected frame.
    always @(negedge clk) begin
        if (rst) active = 0;
        else begin
            if (!active && tx === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame tx=0 with empty scoreboard");
                end else begin
                    cur = sb.pop_front();
                    active = 1;
                    idx = 0;
                    mis = 0;
                end
            end
            if (active) begin
                if (tx !== cur.bits[idx / cur.pre] || busy !== 1'b1) mis++;
`ifndef UART_TX_GEN2_FIFO_EN
                if (rdy !== 1'b0) mis++;
`endif
                idx++;
                if (idx == cur.nb * cur.pre) begin
                    checks++;
                    n_frames++;
                    if (mis != 0) begin
                        errors++;
                        $display("FAIL frame%0d bad_cycles=%0d of %0d", n_frames, mis, idx);
                    end
                    active = 0;
                end
            end else if (tx !== 1'b0) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_busy got=%b exp=0", busy);
                end
            end
        end
    end

    task automatic offer(input logic [7:0] d, input logic pe, input logic pt, input logic s2,
                         input logic [7:0] p, output logic acc);
        @(negedge clk);
        p_data = d; par_en = pe; par_typ = pt; stop2 = s2; prescale = p; dv = 1'b1;
        #1;
        acc = rdy;
        if (acc) sb.push_back(mk(d, pe, pt, s2, p));
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic s2, input logic [7:0] p);
        logic acc;
        int t;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 3000) begin
            offer(d, pe, pt, s2, p, acc);
            t++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=no_accept exp=accept");
        end
        @(negedge clk);
        dv = 1'b0;
    endtask

    task automatic capture(input int n, output logic [63:0] v, output int nb);
        v = '0;
        nb = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v[i] = tx;
            nb += int'(busy);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || active || busy) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 64'(t >= 20000), 64'd0);
    endtask

    initial begin
        logic [63:0] v;
        int nb, acc_n, f0;
        logic acc;
        logic [4:0] accs;
        rst = 1'b1; dv = 1'b0; p_data = '0; par_en = 0; par_typ = 0; stop2 = 0; prescale = 8'd1;
        repeat (3) @(negedge clk);
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(rdy), 64'd1);
        rst = 1'b0;

        send(8'hA5, 0, 0, 0, 8'd1);
        chk("latency_tx_high", 64'(tx), 64'd1);
        capture(10, v, nb);
        chk("a5_bits", v, 64'h34A);
        chk("a5_busy_len", 64'(nb), 64'd10);
        @(negedge clk);
        chk("a5_busy_end", 64'(busy), 64'd0);

        send(8'h03, 1, 1, 1, 8'd4);
        capture(48, v, nb);
        chk("odd_parity", 64'(v[39:36]), 64'hF);
        chk("stop2_8cyc", 64'(v[47:40]), 64'hFF);
        chk("odd_len48", 64'(nb), 64'd48);
        @(negedge clk);
        chk("odd_busy_end", 64'(busy), 64'd0);

        send(8'hFF, 1, 0, 0, 8'd0);
        capture(11, v, nb);
        chk("pre0_bits", v, 64'h5FE);
        chk("pre0_len", 64'(nb), 64'd11);
        wait_idle();

`ifdef UART_TX_GEN2_FIFO_EN
        send(8'h11, 0, 0, 0, 8'd2);
        while (busy !== 1'b1) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            offer(8'h20 + 8'(i), 0, 0, 0, 8'd2, acc);
            accs[i] = acc;
        end
        @(negedge clk);
        dv = 1'b0;
        chk("fifo_accept_map", 64'(accs), 64'h0F);
        begin
            int gap = 0, t = 0;
            while (sb.size() != 0 && t < 2000) begin
                @(negedge clk);
                t++;
                if (busy !== 1'b1) gap++;
            end
            chk("b2b_busy_gaps", 64'(gap), 64'd0);
        end
        wait_idle();
`endif

        f0 = n_frames;
        acc_n = 0;
        for (int i = 0; i < 150; i++) begin
            offer(8'($urandom), 0, 0, 0, 8'd1, acc);
            acc_n += int'(acc);
        end
        @(negedge clk);
        dv = 1'b0;
        wait_idle();
        chk("held_valid_one_per_frame", 64'(acc_n), 64'(n_frames - f0));
`ifndef UART_TX_GEN2_FIFO_EN
        chk("held_valid_accepts", 64'(acc_n), 64'd13);
`endif

        send(8'h52, 0, 0, 0, 8'd2);
`ifdef UART_TX_GEN2_FIFO_EN
        send(8'h99, 0, 0, 0, 8'd2);
        send(8'h66, 0, 0, 0, 8'd2);
`endif
        while (busy !== 1'b1) @(negedge clk);
        repeat (8) @(negedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_tx", 64'(tx), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(rdy), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        capture(5, v, nb);
        chk("no_resume_tx", 64'(v[4:0]), 64'h1F);
        chk("no_resume_busy", 64'(nb), 64'd0);
        send(8'hC3, 1, 0, 1, 8'd3);
        wait_idle();

        for (int i = 0; i < 25; i++) begin
            send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 15)) @(negedge clk);
        end
        wait_idle();
        chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
